seven_seg_decoder: RTL

// - Receive-side counterpart of the seven_seg display driver: monitors multiplexed an/seg lines and reconstructs the 4-digit hex value shown.
// - Decodes active-low segment patterns back to nibbles, collects one digit per anode dwell, publishes a 16-bit word once all four digits are seen.
// - Used for loopback self-test of the display path and for MicroBlaze GPIO read-back.

---
 rtl/seven_seg_pkg.sv | 13 +
 rtl/seven_seg_decoder_if.sv | 22 ++
 rtl/seg_glyph_decode.sv | 21 ++
 rtl/seven_seg_decoder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment glyph table (active-low seg[6:0] = g..a) and digit type.
package seven_seg_pkg;

    typedef logic [3:0] nibble_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seven_seg_decoder_if.sv
// Display-side lines plus reconstructed frame; master drives the display, slave decodes it.
interface seven_seg_decoder_if;

    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        valid;
    logic        bad_digit;
    logic        stale;

    modport master (
        output seg, an,
        input  value, dp, valid, bad_digit, stale
    );

    modport slave (
        input  seg, an,
        output value, dp, valid, bad_digit, stale
    );

endinterface

// File: rtl/seg_glyph_decode.sv
// Combinational active-low segment pattern -> hex nibble; hit_o low when no glyph matches.
module seg_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       hit_o,
    output nibble_t    nibble_o
);

    always_comb begin
        hit_o    = 1'b0;
        nibble_o = '0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_GLYPH[i]) begin
                hit_o    = 1'b1;
                nibble_o = nibble_t'(i);
            end
        end
    end

endmodule

// File: rtl/seven_seg_decoder.sv
// Rebuilds the 4-digit hex word from multiplexed an/seg lines; valid pulses SETTLE_CYCLES+2 after the last digit appears.
// No backpressure: pure monitor, each completed frame is published once and held until the next.
module seven_seg_decoder
    import seven_seg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic                clk,
    input  logic                reset,
    seven_seg_decoder_if.slave  bus
);

    localparam int STW = $clog2(SETTLE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES);
    localparam logic [STW-1:0] SETTLE_MAX = STW'(SETTLE_CYCLES);
    localparam logic [TOW-1:0] TO_LAST    = TOW'(TIMEOUT_CYCLES - 1);

    logic [3:0]     an_q;
    logic [7:0]     seg_q;
    logic [11:0]    prev_q;
    logic [STW-1:0] stab_q, stab_d;
    logic [TOW-1:0] tmo_q, tmo_d;
    logic [3:0]     seen_q, seen_d;
    logic           err_q, err_d;
    logic           stale_q, stale_d;
    nibble_t        shadow_q [NUM_DIGITS];
    logic [3:0]     dp_shadow_q;
    logic [15:0]    value_q, value_d;
    logic [3:0]     dp_q, dp_d;
    logic           valid_q;
    logic           bad_q;

    logic           same, capture, blank, onehot;
    logic           cap_digit, cap_bad, frame_done, restart;
    logic [3:0]     dig_sel;
    logic           glyph_hit;
    nibble_t        glyph_nib, cap_nib;

    seg_glyph_decode u_glyph (
        .seg_i    (seg_q[6:0]),
        .hit_o    (glyph_hit),
        .nibble_o (glyph_nib)
    );

    assign same       = ({an_q, seg_q} == prev_q);
    assign capture    = same && (stab_q == SETTLE_MAX - 1'b1);
    assign dig_sel    = ~an_q;
    assign blank      = (an_q == 4'hF);
    assign onehot     = $onehot(dig_sel);
    assign cap_digit  = capture && onehot;
    assign cap_bad    = capture && !blank && !onehot;
    assign restart    = cap_digit || cap_bad;
    assign frame_done = cap_digit && ((seen_q | dig_sel) == 4'hF);
    assign cap_nib    = glyph_hit ? glyph_nib : nibble_t'(0);

    // Published word merges the digit captured this cycle with the shadows.
    always_comb begin
        value_d = '0;
        dp_d    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            value_d[k*4 +: 4] = dig_sel[k] ? cap_nib : shadow_q[k];
            dp_d[k]           = dig_sel[k] ? ~seg_q[7] : dp_shadow_q[k];
        end
    end

    always_comb begin
        stab_d  = stab_q;
        tmo_d   = tmo_q;
        seen_d  = seen_q;
        err_d   = err_q;
        stale_d = stale_q;

        if (!same)
            stab_d = '0;
        else if (stab_q != SETTLE_MAX)
            stab_d = stab_q + 1'b1;

        if (restart)
            tmo_d = '0;
        else if (tmo_q != TO_LAST)
            tmo_d = tmo_q + 1'b1;

        if (cap_digit) begin
            if (frame_done) begin
                seen_d  = '0;
                err_d   = 1'b0;
                stale_d = 1'b0;
            end else begin
                seen_d = seen_q | dig_sel;
                if (!glyph_hit)
                    err_d = 1'b1;
            end
        end else if (cap_bad) begin
            err_d = 1'b1;
        end else if (tmo_q == TO_LAST) begin
            // Counter parks here, so the partial frame keeps being discarded until a capture.
            seen_d  = '0;
            err_d   = 1'b0;
            stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an_q        <= 4'hF;
            seg_q       <= 8'hFF;
            prev_q      <= 12'hFFF;
            stab_q      <= '0;
            tmo_q       <= '0;
            seen_q      <= '0;
            err_q       <= 1'b0;
            stale_q     <= 1'b0;
            dp_shadow_q <= '0;
            value_q     <= '0;
            dp_q        <= '0;
            valid_q     <= 1'b0;
            bad_q       <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++)
                shadow_q[k] <= '0;
        end else begin
            an_q    <= bus.an;
            seg_q   <= bus.seg;
            prev_q  <= {an_q, seg_q};
            stab_q  <= stab_d;
            tmo_q   <= tmo_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
            stale_q <= stale_d;
            valid_q <= frame_done;

            if (cap_digit) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (dig_sel[k]) begin
                        shadow_q[k]    <= cap_nib;
                        dp_shadow_q[k] <= ~seg_q[7];
                    end
                end
            end

            if (frame_done) begin
                value_q <= value_d;
                dp_q    <= dp_d;
                bad_q   <= err_q || !glyph_hit;
            end
        end
    end

    assign bus.value     = value_q;
    assign bus.dp        = dp_q;
    assign bus.valid     = valid_q;
    assign bus.bad_digit = bad_q;
    assign bus.stale     = stale_q;

endmodule
